// File: rtl/rsa_modexp_ctrl.sv
// RSA modular-exponentiation controller with its Montgomery-ladder core. Latency: accept->go 2 cycles, core done->result_valid 1 cycle.
// Backpressure: start is taken only while ready; result/err are held until result_ack; abort or timeout flushes the core.

// Constant-time ladder core: one exponent bit per cycle, MSB first, done pulses width cycles after go.
module mont_lad #(
  parameter int unsigned width = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [width-1:0] E,
  input  logic [width-1:0] N,
  input  logic [width-1:0] X,
  output logic             done,
  output logic [width-1:0] O
);
  localparam int unsigned CW = $clog2(width + 1);

  logic [width-1:0] r0_q, r1_q, e_q, n_q;
  logic [width-1:0] sel, prod, sq;
  logic [CW-1:0]    cnt_q;
  logic             run_q, done_q;

  // Invariant r1 = r0 * X keeps the work per bit independent of the key.
  assign sel  = e_q[width-1] ? r1_q : r0_q;
  assign prod = width'(({{width{1'b0}}, r0_q} * {{width{1'b0}}, r1_q}) % {{width{1'b0}}, n_q});
  assign sq   = width'(({{width{1'b0}}, sel} * {{width{1'b0}}, sel}) % {{width{1'b0}}, n_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q   <= '0;
      r1_q   <= '0;
      e_q    <= '0;
      n_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        r0_q  <= width'(1);
        r1_q  <= X;
        e_q   <= E;
        n_q   <= N;
        cnt_q <= CW'(width);
        run_q <= 1'b1;
      end else if (run_q) begin
        r0_q  <= e_q[width-1] ? prod : sq;
        r1_q  <= e_q[width-1] ? sq : prod;
        e_q   <= {e_q[width-2:0], 1'b0};
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign O    = r0_q;
endmodule

module rsa_modexp_ctrl #(
  parameter int unsigned      WIDTH      = 2048,
  parameter int unsigned      TMO_W      = 32,
  parameter logic [TMO_W-1:0] MAX_CYCLES = TMO_W'(32'hFFFF_FFFF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] message_in,
  input  logic [WIDTH-1:0] exp_pub,
  input  logic [WIDTH-1:0] exp_priv,
  input  logic [WIDTH-1:0] modulus,
  input  logic             abort,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [TMO_W-1:0] cycle_count
);
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = MAX_CYCLES - TMO_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, e_q, e_d, n_q, n_d, res_q, res_d;
  logic [1:0]       code_q, code_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             go_q, go_d, flush_q, flush_d;
  logic             ready_q, busy_q, rv_q, err_q;
  logic             core_go, core_rst, core_done;
  logic [WIDTH-1:0] core_o;

  assign core_go  = go_q;
  assign core_rst = rst | flush_q;

  mont_lad #(.width(WIDTH)) u_core (
    .clk  (clk),
    .rst  (core_rst),
    .go   (core_go),
    .E    (e_q),
    .N    (n_q),
    .X    (x_q),
    .done (core_done),
    .O    (core_o)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    e_d     = e_q;
    n_d     = n_q;
    res_d   = res_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    go_d    = 1'b0;
    flush_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = message_in;
          n_d     = modulus;
          e_d     = mode ? exp_priv : exp_pub;
          cnt_d   = '0;
          code_d  = 2'b00;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_ERR;
          code_d  = 2'b11;
          flush_d = 1'b1;
        end else if (n_q == '0 || !n_q[0]) begin
          state_d = S_ERR;
          code_d  = 2'b01;
        end else if (x_q >= n_q) begin
          state_d = S_ERR;
          code_d  = 2'b10;
        end else begin
          state_d = S_LAUNCH;
          go_d    = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          state_d = S_ERR;
          code_d  = 2'b11;
          flush_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + TMO_W'(1);
        // Abort beats done, done beats the timeout landing on the same cycle.
        if (abort) begin
          state_d = S_ERR;
          code_d  = 2'b11;
          flush_d = 1'b1;
        end else if (core_done) begin
          res_d   = core_o;
          state_d = S_DONE;
        end else if (MAX_CYCLES != '0 && cnt_q == TMO_LAST) begin
          state_d = S_ERR;
          code_d  = 2'b11;
          flush_d = 1'b1;
        end
      end
      S_DONE: begin
        if (result_ack) state_d = S_IDLE;
      end
      S_ERR: begin
        if (result_ack) begin
          state_d = S_IDLE;
          code_d  = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) res_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
      code_q  <= 2'b00;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      flush_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      e_q     <= e_d;
      n_q     <= n_d;
      res_q   <= res_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      flush_q <= flush_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d inside {S_CHECK, S_LAUNCH, S_WAIT});
      rv_q    <= (state_d inside {S_DONE, S_ERR});
      err_q   <= (state_d == S_ERR);
    end
  end

  assign ready        = ready_q;
  assign busy         = busy_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign err          = err_q;
  assign err_code     = code_q;
  assign cycle_count  = cnt_q;
endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
- Parametrised successor to the single-mode RSA top-level controller.
- Wraps one mont_lad core (parameter width; ports clk, go, rst, done, E, N, O, X) behind a start/ready input handshake and a valid/ack result handshake.
- Adds runtime encrypt/decrypt mode select, operand validity checks, a cycle-count timeout, abort with core flush, and error reporting.
- Sits between the bus/register front-end and the modular-exponentiation core.

Parameters:
- WIDTH, 2048, operand width in bits for message, exponents, modulus and result; passed to mont_lad as width.
- TMO_W, 32, width of the cycle counter and the timeout limit.
- MAX_CYCLES, 32'hFFFF_FFFF, cycles allowed in WAIT before a timeout error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only when start && ready
- ready  out  1  high in IDLE only
- mode  in  1  0 = encrypt (use exp_pub), 1 = decrypt (use exp_priv); sampled at accept
- message_in  in  WIDTH  operand X, captured at accept
- exp_pub  in  WIDTH  public exponent, captured at accept
- exp_priv  in  WIDTH  private exponent, captured at accept
- modulus  in  WIDTH  modulus N, captured at accept
- abort  in  1  cancel the operation in flight
- result  out  WIDTH  core output, held stable while result_valid
- result_valid  out  1  result or error available
- result_ack  in  1  consumer acknowledge
- busy  out  1  high in CHECK, LAUNCH, WAIT
- err  out  1  qualifies result_valid as an error completion
- err_code  out  2  00 none, 01 modulus zero/even, 10 message >= modulus, 11 timeout or abort
- cycle_count  out  TMO_W  cycles spent in WAIT for the last operation

Behaviour:
- Reset values: ready=0 for the reset cycle, then 1 in IDLE. All other outputs reset to 0; internal operand registers reset to 0. Core rst = rst OR flush.
- State machine: IDLE, CHECK, LAUNCH, WAIT, DONE, ERR.
- IDLE:
  - ready=1.
  - On start: capture message_in, modulus, and the exponent selected by mode into internal registers, clear cycle_count, go to CHECK. Inputs are never read after accept.
- CHECK (1 cycle):
  - N==0 or N[0]==0 → ERR with code 01.
  - else X >= N (unsigned, full WIDTH) → ERR with code 10.
  - else → LAUNCH.
  - Code 01 takes priority over code 10.
- LAUNCH (1 cycle): core go=1 for exactly this cycle, then WAIT.
- WAIT:
  - cycle_count increments each cycle and saturates at all-ones.
  - Core done → capture core O into result, go to DONE.
  - MAX_CYCLES != 0 and cycle_count == MAX_CYCLES-1 without done → ERR with code 11, assert flush for one cycle.
  - If done and the timeout fire in the same cycle, done wins.
- Abort:
  - Abort in CHECK, LAUNCH or WAIT → ERR with code 11, one-cycle flush. Abort takes priority over done in the same cycle.
  - Abort in IDLE, DONE or ERR is ignored.
- DONE: result_valid=1, err=0, result held. On result_ack → IDLE; result_valid drops the cycle after ack.
- ERR: result_valid=1, err=1, err_code held, result forced to 0. On result_ack → IDLE, err and err_code clear.
- result_ack outside DONE/ERR is ignored. start outside IDLE is ignored and is not queued.
- Latency: accept → core go = 2 cycles; core done → result_valid = 1 cycle; accept → ERR for check failures = 2 cycles.
- Back-to-back: ack in DONE gives IDLE next cycle, and a new start can be accepted in that cycle.
- Async rst mid-operation returns to IDLE on the next clock and resets the core; no result_valid is produced for the lost operation.

Test Plan:
- WIDTH=16, mode=0, N=3233, e=17, X=65, start pulse → go pulse 2 cycles after accept; result=2790, result_valid=1, err=0; holds until ack, then ready=1.
- mode=1, d=2753, X=2790, N=3233 → result=65; exp_pub is ignored (drive it to 0xFFFF to prove this).
- N=3234 → ERR with err_code=01 after 2 cycles, core go never asserted. N=0 → code 01. N=3233, X=4000 → code 10.
- MAX_CYCLES=5 with the core stalled (done never asserts) → err_code=11 on the 5th WAIT cycle, cycle_count=5, one-cycle core reset pulse. Repeat with done and the timeout coincident → normal result.
- Abort 3 cycles into WAIT → err_code=11, flush pulse; next operation (N=3233, e=17, X=65) completes with 2790. Abort in IDLE has no effect.
- start held high across DONE with no ack → exactly one accept; assert async rst in WAIT → outputs at reset values, ready=1 after reset release, no spurious result_valid.
